tlk2711_tx_framer: RTL and testbench

//  Downstream of the TX command/DMA-read stage: consumes 64-bit MM2S DMA beats plus packet_body/packet_tail/send_start,

---
 rtl/tlk2711_tx_framer.sv | 192 +++++++++++++++++++
 tb/tb_tlk2711_tx_framer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_tx_framer.sv
// TLK2711 transmit framer: turns 64-bit MM2S beats into framed 16-bit line words
// (SOF, header, payload, checksum, EOF) with K-flags and idle fill between packets.
module tlk2711_tx_framer #(
    parameter int          BODY_BEATS = 205,
    parameter int          GAP_CYCLES = 4,
    parameter logic [15:0] IDLE_WORD  = 16'hC5BC,
    parameter logic [15:0] SOF_WORD   = 16'hFBFB,
    parameter logic [15:0] EOF_WORD   = 16'hFDFD
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_soft_rst,
    input  logic        i_send_start,
    input  logic [21:0] i_packet_body,
    input  logic [9:0]  i_packet_tail,
    input  logic [63:0] i_s_tdata,
    input  logic        i_s_tvalid,
    output logic        o_s_tready,
    output logic [15:0] o_txd,
    output logic        o_tkmsb,
    output logic        o_tklsb,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_underrun,
    output logic [15:0] o_pkt_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_HDR,
        S_PAY,
        S_CSUM,
        S_EOF,
        S_GAP
    } state_t;

    localparam logic [15:0] BODY_BEATS_W = 16'(BODY_BEATS);
    localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);

    state_t      r_state;
    logic [21:0] r_body;
    logic [9:0]  r_tail;
    logic [22:0] r_pkts_total;
    logic [22:0] r_pkt_num;
    logic [15:0] r_beat_cnt;
    logic [15:0] r_gap_cnt;
    logic [15:0] r_sum;
    logic [63:0] r_hold;
    logic        r_full;
    logic [1:0]  r_widx;

    logic        w_rst;
    logic [22:0] w_total_in;
    logic        w_last_pkt;
    logic [15:0] w_beats_m1;
    logic        w_last_beat;
    logic        w_accept;
    logic [15:0] w_word;

    assign w_rst      = i_rst | i_soft_rst;
    assign w_total_in = {1'b0, i_packet_body} + {22'd0, (i_packet_tail != 10'd0)};
    assign w_last_pkt = (r_pkt_num == (r_pkts_total - 23'd1));
    assign w_beats_m1 = ((w_last_pkt && (r_tail != 10'd0)) ? {6'd0, r_tail} : BODY_BEATS_W) - 16'd1;
    assign w_last_beat = (r_beat_cnt == w_beats_m1);
    assign w_word     = r_hold[{r_widx, 4'b0000} +: 16];

    // Prefetch the next beat while the 4th word of the current one goes out, but never
    // pull a beat past the end of the packet; gated by reset so no beat is lost in that cycle.
    assign o_s_tready = !w_rst &&
                        (((r_state == S_HDR) && !r_full) ||
                         ((r_state == S_PAY) && (!r_full || ((r_widx == 2'd3) && !w_last_beat))));
    assign w_accept   = o_s_tready && i_s_tvalid;
    assign o_busy     = (r_state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            // NOTE: only the valid flag of the holding register is reset; its data is
            // never read while r_full is low, so it needs no reset of its own.
            r_state      <= S_IDLE;
            r_full       <= 1'b0;
            r_widx       <= 2'd0;
            r_body       <= 22'd0;
            r_tail       <= 10'd0;
            r_pkts_total <= 23'd0;
            r_pkt_num    <= 23'd0;
            r_beat_cnt   <= 16'd0;
            r_gap_cnt    <= 16'd0;
            r_sum        <= 16'd0;
            o_txd        <= IDLE_WORD;
            {o_tkmsb, o_tklsb} <= 2'b01;
            o_done       <= 1'b0;
            o_underrun   <= 1'b0;
            o_pkt_cnt    <= 16'd0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every branch sees the
            // pre-edge values; a later assignment in the same cycle overrides an earlier one.
            o_done <= 1'b0;
            if (w_accept) begin
                r_hold <= i_s_tdata;
                r_full <= 1'b1;
                r_widx <= 2'd0;
            end

            case (r_state)
                S_IDLE: begin
                    o_txd              <= IDLE_WORD;
                    {o_tkmsb, o_tklsb} <= 2'b01;
                    if (i_send_start) begin
                        r_body       <= i_packet_body;
                        r_tail       <= i_packet_tail;
                        r_pkts_total <= w_total_in;
                        r_pkt_num    <= 23'd0;
                        o_pkt_cnt    <= 16'd0;
                        o_underrun   <= 1'b0;
                        if (w_total_in != 23'd0) begin
                            r_state <= S_SOF;
                        end else begin
                            o_done <= 1'b1;
                        end
                    end
                end
                S_SOF: begin
                    o_txd              <= SOF_WORD;
                    {o_tkmsb, o_tklsb} <= 2'b11;
                    r_sum              <= 16'd0;
                    r_beat_cnt         <= 16'd0;
                    r_state            <= S_HDR;
                end
                S_HDR: begin
                    o_txd              <= r_pkt_num[15:0];
                    {o_tkmsb, o_tklsb} <= 2'b00;
                    r_state            <= S_PAY;
                end
                S_PAY: begin
                    if (r_full) begin
                        o_txd              <= w_word;
                        {o_tkmsb, o_tklsb} <= 2'b00;
                        r_sum              <= r_sum + w_word;
                        if (r_widx == 2'd3) begin
                            if (!w_accept) begin
                                r_full <= 1'b0;
                            end
                            if (w_last_beat) begin
                                r_state <= S_CSUM;
                            end else begin
                                r_beat_cnt <= r_beat_cnt + 16'd1;
                            end
                        end else begin
                            r_widx <= r_widx + 2'd1;
                        end
                    end else begin
                        // Starved: pad with idle, nothing counted or summed.
                        o_txd              <= IDLE_WORD;
                        {o_tkmsb, o_tklsb} <= 2'b01;
                        o_underrun         <= 1'b1;
                    end
                end
                S_CSUM: begin
                    o_txd              <= r_sum;
                    {o_tkmsb, o_tklsb} <= 2'b00;
                    r_state            <= S_EOF;
                end
                S_EOF: begin
                    o_txd              <= EOF_WORD;
                    {o_tkmsb, o_tklsb} <= 2'b11;
                    o_pkt_cnt          <= o_pkt_cnt + 16'd1;
                    if (w_last_pkt) begin
                        o_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_pkt_num <= r_pkt_num + 23'd1;
                        r_gap_cnt <= 16'd0;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    o_txd              <= IDLE_WORD;
                    {o_tkmsb, o_tklsb} <= 2'b01;
                    r_gap_cnt          <= r_gap_cnt + 16'd1;
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_SOF;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlk2711_tx_framer.sv
// Directed bench for tlk2711_tx_framer with BODY_BEATS=2, GAP_CYCLES=4;
// the captured line stream is compared against hand-written expected word lists.
module tb_tlk2711_tx_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        soft_rst;
    logic        send_start;
    logic [21:0] packet_body;
    logic [9:0]  packet_tail;
    logic [63:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [15:0] txd;
    logic        tkmsb;
    logic        tklsb;
    logic        busy;
    logic        done;
    logic        underrun;
    logic [15:0] pkt_cnt;

    int checks   = 0;
    int failures = 0;

    logic [63:0] feed_q[$];
    int          feed_idx   = 0;
    int          accepted   = 0;
    int          stall_at   = -1;
    int          stall_left = 0;

    logic [17:0] mon_q[$];
    logic [17:0] exp_q[$];
    bit          cap_en = 1'b0;

    tlk2711_tx_framer #(
        .BODY_BEATS(2),
        .GAP_CYCLES(4)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_soft_rst   (soft_rst),
        .i_send_start (send_start),
        .i_packet_body(packet_body),
        .i_packet_tail(packet_tail),
        .i_s_tdata    (s_tdata),
        .i_s_tvalid   (s_tvalid),
        .o_s_tready   (s_tready),
        .o_txd        (txd),
        .o_tkmsb      (tkmsb),
        .o_tklsb      (tklsb),
        .o_busy       (busy),
        .o_done       (done),
        .o_underrun   (underrun),
        .o_pkt_cnt    (pkt_cnt)
    );

    always #5 clk = ~clk;

    // DMA source: advances on handshake; a stall withholds tvalid for 5 tready cycles.
    always @(posedge clk) begin
        if (s_tvalid && s_tready) begin
            feed_idx++;
            accepted++;
        end
        if (stall_left > 0 && s_tready) stall_left--;
        #1;
        if (stall_at >= 0 && accepted == stall_at) begin
            stall_left = 5;
            stall_at   = -1;
        end
        s_tvalid = (feed_idx < feed_q.size()) && (stall_left == 0);
        s_tdata  = (feed_idx < feed_q.size()) ? feed_q[feed_idx] : 64'd0;
    end

    always @(negedge clk) begin
        if (cap_en) mon_q.push_back({tkmsb, tklsb, txd});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start(input logic [21:0] body, input logic [9:0] tail);
        send_start  = 1'b1;
        packet_body = body;
        packet_tail = tail;
        @(negedge clk);
        send_start  = 1'b0;
    endtask

    task automatic new_feed();
        feed_q.delete();
        feed_idx   = 0;
        accepted   = 0;
        stall_at   = -1;
        stall_left = 0;
        mon_q.delete();
        exp_q.delete();
    endtask

    task automatic push(input logic [1:0] k, input logic [15:0] w);
        exp_q.push_back({k, w});
    endtask

    task automatic push_pkt_edges_payload(input logic [15:0] hdr, input logic [15:0] first,
                                          input int n, input logic [15:0] sum);
        push(2'b11, 16'hFBFB);
        push(2'b00, hdr);
        for (int i = 0; i < n; i++) push(2'b00, first + 16'(i));
        push(2'b00, sum);
        push(2'b11, 16'hFDFD);
    endtask

    // Waits for o_done; at that sample the final EOF must be on the line.
    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        check({tag, "_eof_at_done"}, {14'd0, tkmsb, tklsb, txd}, {14'd0, 2'b11, 16'hFDFD});
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic compare_stream(input string tag);
        int s = -1;
        for (int i = 0; i < mon_q.size(); i++) begin
            if (s < 0 && mon_q[i] == {2'b11, 16'hFBFB}) s = i;
        end
        check({tag, "_sof_found"}, {31'd0, (s >= 0)}, 32'd1);
        if (s >= 0) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                check($sformatf("%s_w%0d", tag, i),
                      (s + i < mon_q.size()) ? {14'd0, mon_q[s + i]} : 32'hDEAD_BEEF,
                      {14'd0, exp_q[i]});
            end
        end
    endtask

    initial begin
        rst = 1'b1; soft_rst = 1'b0; send_start = 1'b0;
        packet_body = '0; packet_tail = '0;
        s_tdata = '0; s_tvalid = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_txd", {16'd0, txd}, 32'h0000_C5BC);
        check("rst_k", {30'd0, tkmsb, tklsb}, 32'd1);
        check("rst_tready", {31'd0, s_tready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        check("rst_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);

        // Test 1: reset mid-payload.
        new_feed();
        feed_q.push_back(64'h0004_0003_0002_0001);
        feed_q.push_back(64'h0008_0007_0006_0005);
        start(22'd1, 10'd0);
        tick(4);
        check("t1_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t1_txd", {16'd0, txd}, 32'h0000_C5BC);
        check("t1_k", {30'd0, tkmsb, tklsb}, 32'd1);
        check("t1_tready", {31'd0, s_tready}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);
        check("t1_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
        tick(3);

        // Test 2: one packet of two beats.
        new_feed();
        feed_q.push_back(64'h0004_0003_0002_0001);
        feed_q.push_back(64'h0008_0007_0006_0005);
        push_pkt_edges_payload(16'h0000, 16'h0001, 8, 16'h0024);
        cap_en = 1'b1;
        start(22'd1, 10'd0);
        wait_done("t2", 100);
        check("t2_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
        check("t2_underrun", {31'd0, underrun}, 32'd0);
        check("t2_busy", {31'd0, busy}, 32'd0);
        compare_stream("t2");
        cap_en = 1'b0;

        // Test 3: two full packets plus a one-beat tail packet.
        new_feed();
        feed_q.push_back(64'h0004_0003_0002_0001);
        feed_q.push_back(64'h0008_0007_0006_0005);
        feed_q.push_back(64'h000C_000B_000A_0009);
        feed_q.push_back(64'h0010_000F_000E_000D);
        feed_q.push_back(64'h1000_0100_0010_0001);
        push_pkt_edges_payload(16'h0000, 16'h0001, 8, 16'h0024);
        for (int i = 0; i < 4; i++) push(2'b01, 16'hC5BC);
        push_pkt_edges_payload(16'h0001, 16'h0009, 8, 16'h0064);
        for (int i = 0; i < 4; i++) push(2'b01, 16'hC5BC);
        push(2'b11, 16'hFBFB);
        push(2'b00, 16'h0002);
        push(2'b00, 16'h0001);
        push(2'b00, 16'h0010);
        push(2'b00, 16'h0100);
        push(2'b00, 16'h1000);
        push(2'b00, 16'h1111);
        push(2'b11, 16'hFDFD);
        cap_en = 1'b1;
        start(22'd2, 10'd1);
        wait_done("t3", 200);
        check("t3_pkt_cnt", {16'd0, pkt_cnt}, 32'd3);
        check("t3_underrun", {31'd0, underrun}, 32'd0);
        compare_stream("t3");
        cap_en = 1'b0;

        // Test 4: source stalls for 5 cycles after the first beat.
        new_feed();
        feed_q.push_back(64'h0004_0003_0002_0001);
        feed_q.push_back(64'h0008_0007_0006_0005);
        stall_at = 1;
        push(2'b11, 16'hFBFB);
        push(2'b00, 16'h0000);
        for (int i = 1; i <= 4; i++) push(2'b00, 16'(i));
        for (int i = 0; i < 5; i++) push(2'b01, 16'hC5BC);
        for (int i = 5; i <= 8; i++) push(2'b00, 16'(i));
        push(2'b00, 16'h0024);
        push(2'b11, 16'hFDFD);
        cap_en = 1'b1;
        start(22'd1, 10'd0);
        wait_done("t4", 100);
        check("t4_underrun", {31'd0, underrun}, 32'd1);
        check("t4_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
        compare_stream("t4");
        cap_en = 1'b0;

        // Test 5: checksum wrap, start while busy ignored, empty transfer.
        new_feed();
        feed_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        feed_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        push(2'b11, 16'hFBFB);
        push(2'b00, 16'h0000);
        for (int i = 0; i < 8; i++) push(2'b00, 16'hFFFF);
        push(2'b00, 16'hFFF8);
        push(2'b11, 16'hFDFD);
        cap_en = 1'b1;
        start(22'd1, 10'd0);
        check("t5_underrun_cleared", {31'd0, underrun}, 32'd0);
        tick(3);
        start(22'd5, 10'd0);
        wait_done("t5", 100);
        check("t5_pkt_cnt", {16'd0, pkt_cnt}, 32'd1);
        compare_stream("t5");
        cap_en = 1'b0;
        tick(10);
        check("t5_no_restart_busy", {31'd0, busy}, 32'd0);
        check("t5_no_restart_cnt", {16'd0, pkt_cnt}, 32'd1);

        start(22'd0, 10'd0);
        check("t5_empty_done", {31'd0, done}, 32'd1);
        check("t5_empty_busy", {31'd0, busy}, 32'd0);
        tick(1);
        check("t5_empty_done_pulse", {31'd0, done}, 32'd0);
        check("t5_empty_pkt_cnt", {16'd0, pkt_cnt}, 32'd0);
        check("t5_empty_txd", {16'd0, txd}, 32'h0000_C5BC);
        check("t5_empty_tready", {31'd0, s_tready}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
